// File: rtl/fpu_fma_pkg.sv
// Shared types for the FMA scheduling slice: the single-precision float
// layout, scheduler states and a zero-operand helper.
package fpu_fma_pkg;

    localparam int FP      = 32;
    localparam int EXPBITS = 8;
    localparam int MANBITS = 23;

    typedef struct packed {
        logic               sign;
        logic [EXPBITS-1:0] exponent;
        logic [MANBITS-1:0] mantissa;
    } float_sp;

    typedef enum logic [1:0] {
        FMA_IDLE,
        FMA_BUSY,
        FMA_DONE
    } fma_state_e;

    typedef enum logic {
        FALSE = 1'b0,
        TRUE  = 1'b1
    } bool_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DRAIN,
        S_RESPOND
    } sched_state_e;

    // Signed zero (either sign) counts as zero.
    function automatic logic is_zero(input float_sp f);
        return {f.exponent, f.mantissa} == '0;
    endfunction

endpackage

// File: rtl/fma_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first request at or after ptr+1,
// wrapping modulo NREQ.
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IW-1:0]   ptr_i,
    output logic [NREQ-1:0] grant_o,
    output logic [IW-1:0]   idx_o,
    output logic            valid_o
);

    int j;

    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        j       = 0;
        for (int k = 1; k <= NREQ; k++) begin
            j = (int'(ptr_i) + k) % NREQ;
            if (!valid_o && req_i[j]) begin
                valid_o    = 1'b1;
                grant_o[j] = 1'b1;
                idx_o      = IW'(j);
            end
        end
    end

endmodule

// File: rtl/fma_scheduler.sv
// Shares one single-precision FMA unit among NREQ requesters with
// round-robin grants, local zero handling, issue spacing and a watchdog.
module fma_scheduler
    import fpu_fma_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 12,
    parameter int MIN_GAP = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid_in,
    input  float_sp [NREQ-1:0]   req_a_in,
    input  float_sp [NREQ-1:0]   req_b_in,
    output logic [NREQ-1:0]      req_ready_out,
    output logic [NREQ-1:0]      rsp_valid_out,
    output float_sp              rsp_data_out,
    output logic                 rsp_overflow_out,
    output logic                 rsp_underflow_out,
    output logic                 rsp_timeout_out,
    output float_sp              fma_float_0_out,
    output float_sp              fma_float_1_out,
    output logic                 fma_req_out,
    output logic                 fma_busy_out,
    input  float_sp              fma_answer_in,
    input  logic                 fma_ready_in,
    input  logic                 fma_overflow_in,
    input  logic                 fma_underflow_in
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int GW = $clog2(MIN_GAP + 1);
    localparam int WW = $clog2(TIMEOUT + 1);

    sched_state_e  state_q, state_d;
    logic [IW-1:0] rr_ptr_q, rr_ptr_d;
    logic [IW-1:0] gnt_q, gnt_d;
    float_sp       a_q, a_d;
    float_sp       b_q, b_d;
    float_sp       res_q, res_d;
    logic          ovf_q, ovf_d;
    logic          unf_q, unf_d;
    logic          tmo_q, tmo_d;
    logic [GW-1:0] gap_q, gap_d;
    logic [WW-1:0] wd_q, wd_d;
    logic          drain_q, drain_d;
    logic          rdy_prev_q;

    logic [NREQ-1:0] arb_grant;
    logic [IW-1:0]   arb_idx;
    logic            arb_valid;
    logic [NREQ-1:0] ready_raw;
    float_sp         sel_a;
    float_sp         sel_b;

    rr_arbiter #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_arb (
        .req_i   (req_valid_in),
        .ptr_i   (rr_ptr_q),
        .grant_o (arb_grant),
        .idx_o   (arb_idx),
        .valid_o (arb_valid)
    );

    assign sel_a = req_a_in[arb_idx];
    assign sel_b = req_b_in[arb_idx];

    // The accept pulse is combinational, so hold it off while in reset.
    assign req_ready_out = rst ? ready_raw : '0;

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        gnt_d    = gnt_q;
        a_d      = a_q;
        b_d      = b_q;
        res_d    = res_q;
        ovf_d    = ovf_q;
        unf_d    = unf_q;
        tmo_d    = tmo_q;
        wd_d     = wd_q;
        drain_d  = drain_q;
        gap_d    = (gap_q >= GW'(MIN_GAP)) ? gap_q : gap_q + GW'(1);

        ready_raw         = '0;
        rsp_valid_out     = '0;
        rsp_data_out      = '0;
        rsp_overflow_out  = 1'b0;
        rsp_underflow_out = 1'b0;
        rsp_timeout_out   = 1'b0;
        fma_float_0_out   = '0;
        fma_float_1_out   = '0;
        fma_req_out       = 1'b0;
        fma_busy_out      = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (arb_valid) begin
                    ready_raw = arb_grant;
                    gnt_d     = arb_idx;
                    rr_ptr_d  = arb_idx;
                    a_d       = sel_a;
                    b_d       = sel_b;
                    ovf_d     = 1'b0;
                    unf_d     = 1'b0;
                    tmo_d     = 1'b0;
                    if (is_zero(sel_a) || is_zero(sel_b)) begin
                        res_d   = {sel_a.sign ^ sel_b.sign, 31'b0};
                        state_d = S_RESPOND;
                    end else begin
                        state_d = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                fma_float_0_out = a_q;
                fma_float_1_out = b_q;
                if (gap_q >= GW'(MIN_GAP)) begin
                    fma_req_out = 1'b1;
                    gap_d       = GW'(1);
                    wd_d        = WW'(1);
                    state_d     = S_WAIT;
                end
            end
            S_WAIT: begin
                fma_float_0_out = a_q;
                fma_float_1_out = b_q;
                wd_d            = wd_q + WW'(1);
                if (fma_ready_in && !rdy_prev_q) begin
                    res_d   = fma_answer_in;
                    ovf_d   = fma_overflow_in;
                    unf_d   = fma_underflow_in;
                    drain_d = 1'b0;
                    state_d = S_DRAIN;
                end else if (wd_q >= WW'(TIMEOUT)) begin
                    res_d   = '0;
                    tmo_d   = 1'b1;
                    state_d = S_RESPOND;
                end
            end
            S_DRAIN: begin
                fma_float_0_out = a_q;
                fma_float_1_out = b_q;
                fma_busy_out    = 1'b1;
                drain_d         = 1'b1;
                if (drain_q) begin
                    state_d = S_RESPOND;
                end
            end
            S_RESPOND: begin
                rsp_valid_out[gnt_q] = 1'b1;
                rsp_data_out         = res_q;
                rsp_overflow_out     = ovf_q;
                rsp_underflow_out    = unf_q;
                rsp_timeout_out      = tmo_q;
                state_d              = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            rr_ptr_q   <= IW'(NREQ - 1);
            gnt_q      <= '0;
            a_q        <= '0;
            b_q        <= '0;
            res_q      <= '0;
            ovf_q      <= 1'b0;
            unf_q      <= 1'b0;
            tmo_q      <= 1'b0;
            gap_q      <= GW'(MIN_GAP);
            wd_q       <= '0;
            drain_q    <= 1'b0;
            rdy_prev_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            gnt_q      <= gnt_d;
            a_q        <= a_d;
            b_q        <= b_d;
            res_q      <= res_d;
            ovf_q      <= ovf_d;
            unf_q      <= unf_d;
            tmo_q      <= tmo_d;
            gap_q      <= gap_d;
            wd_q       <= wd_d;
            drain_q    <= drain_d;
            rdy_prev_q <= fma_ready_in;
        end
    end

endmodule

// File: tb/tb_fma_scheduler.sv
// Directed bench for fma_scheduler with a latency-programmable FMA
// responder and per-cycle event logs.
module tb_fma_scheduler;
    import fpu_fma_pkg::*;

    localparam int NREQ = 4;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic [NREQ-1:0]    req_valid_in = '0;
    float_sp [NREQ-1:0] req_a_in = '0;
    float_sp [NREQ-1:0] req_b_in = '0;
    logic [NREQ-1:0]    req_ready_out;
    logic [NREQ-1:0]    rsp_valid_out;
    float_sp            rsp_data_out;
    logic               rsp_overflow_out;
    logic               rsp_underflow_out;
    logic               rsp_timeout_out;
    float_sp            fma_float_0_out;
    float_sp            fma_float_1_out;
    logic               fma_req_out;
    logic               fma_busy_out;
    float_sp            fma_answer_in = '0;
    logic               fma_ready_in = 1'b0;
    logic               fma_overflow_in = 1'b0;
    logic               fma_underflow_in = 1'b0;

    fma_scheduler #(
        .NREQ    (NREQ),
        .TIMEOUT (12),
        .MIN_GAP (8)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .req_valid_in      (req_valid_in),
        .req_a_in          (req_a_in),
        .req_b_in          (req_b_in),
        .req_ready_out     (req_ready_out),
        .rsp_valid_out     (rsp_valid_out),
        .rsp_data_out      (rsp_data_out),
        .rsp_overflow_out  (rsp_overflow_out),
        .rsp_underflow_out (rsp_underflow_out),
        .rsp_timeout_out   (rsp_timeout_out),
        .fma_float_0_out   (fma_float_0_out),
        .fma_float_1_out   (fma_float_1_out),
        .fma_req_out       (fma_req_out),
        .fma_busy_out      (fma_busy_out),
        .fma_answer_in     (fma_answer_in),
        .fma_ready_in      (fma_ready_in),
        .fma_overflow_in   (fma_overflow_in),
        .fma_underflow_in  (fma_underflow_in)
    );

    always #5 clk = ~clk;

    int              cyc = 0;
    int              errors = 0;
    int              checks = 0;
    int              fma_lat = 0;
    logic [31:0]     fma_ans = '0;
    int              ready_at = -1;
    logic [NREQ-1:0] clr_pend = '0;
    int              busy_cnt = 0;

    int              acc_cyc_q[$];
    int              acc_idx_q[$];
    int              req_cyc_q[$];
    logic [31:0]     req_a_q[$];
    int              rsp_cyc_q[$];
    logic [NREQ-1:0] rsp_vec_q[$];
    logic [31:0]     rsp_data_q[$];
    logic [2:0]      rsp_flag_q[$];

    // Observe cycle outputs before the next edge, then drive the new cycle.
    task automatic step();
        @(negedge clk);
        #1;
        if (fma_req_out) begin
            req_cyc_q.push_back(cyc);
            req_a_q.push_back(fma_float_0_out);
            ready_at = (fma_lat > 0) ? cyc + fma_lat : -1;
        end
        if (fma_busy_out) busy_cnt++;
        if (|req_ready_out) begin
            acc_cyc_q.push_back(cyc);
            for (int i = 0; i < NREQ; i++)
                if (req_ready_out[i]) acc_idx_q.push_back(i);
            clr_pend |= req_ready_out;
        end
        if (|rsp_valid_out) begin
            rsp_cyc_q.push_back(cyc);
            rsp_vec_q.push_back(rsp_valid_out);
            rsp_data_q.push_back(rsp_data_out);
            rsp_flag_q.push_back({rsp_overflow_out, rsp_underflow_out,
                                  rsp_timeout_out});
        end
        @(posedge clk);
        cyc++;
        #1;
        req_valid_in &= ~clr_pend;
        clr_pend = '0;
        if (cyc == ready_at) begin
            fma_ready_in  = 1'b1;
            fma_answer_in = fma_ans;
        end else begin
            fma_ready_in = 1'b0;
        end
    endtask

    task automatic wait_rsp(input int target, input int budget,
                            output bit ok);
        int n;
        n = 0;
        while (rsp_cyc_q.size() < target && n < budget) begin
            step();
            n++;
        end
        ok = (rsp_cyc_q.size() >= target);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic test_reset();
        rst = 1'b0;
        req_a_in[0] = 32'h3f800000;
        req_b_in[0] = 32'h3f800000;
        req_valid_in = 4'b1111;
        idle(2);
        checks++;
        if (req_ready_out !== 4'b0000) begin
            errors++;
            $display("FAIL reset_ready got=%b exp=0000", req_ready_out);
        end
        checks++;
        if (rsp_valid_out !== 4'b0000 || rsp_data_out !== 32'h0) begin
            errors++;
            $display("FAIL reset_rsp got=%b/%h exp=0000/0",
                     rsp_valid_out, rsp_data_out);
        end
        checks++;
        if ({fma_req_out, fma_busy_out} !== 2'b00) begin
            errors++;
            $display("FAIL reset_fma got=%b exp=00",
                     {fma_req_out, fma_busy_out});
        end
        checks++;
        if (fma_float_0_out !== 32'h0 || fma_float_1_out !== 32'h0) begin
            errors++;
            $display("FAIL reset_ops got=%h/%h exp=0/0",
                     fma_float_0_out, fma_float_1_out);
        end
        req_valid_in = '0;
        rst = 1'b1;
        idle(2);
        checks++;
        if (acc_cyc_q.size() != 0 || req_cyc_q.size() != 0) begin
            errors++;
            $display("FAIL reset_quiet got=%0d/%0d exp=0/0",
                     acc_cyc_q.size(), req_cyc_q.size());
        end
    endtask

    task automatic test_basic();
        int t0, n_req, n_busy;
        bit ok;
        fma_lat = 3;
        fma_ans = 32'h3f800000;
        n_req = req_cyc_q.size();
        n_busy = busy_cnt;
        req_a_in[0] = 32'h3f800000;
        req_b_in[0] = 32'h3f800000;
        req_valid_in[0] = 1'b1;
        t0 = cyc;
        wait_rsp(1, 40, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL basic_rsp got=none exp=response");
            return;
        end
        checks++;
        if (acc_cyc_q[0] != t0 || acc_idx_q[0] != 0) begin
            errors++;
            $display("FAIL basic_accept got=%0d/%0d exp=%0d/0",
                     acc_cyc_q[0], acc_idx_q[0], t0);
        end
        checks++;
        if (req_cyc_q.size() - n_req != 1 || req_cyc_q[n_req] != t0 + 1) begin
            errors++;
            $display("FAIL basic_req got=%0d pulses exp=1 at %0d",
                     req_cyc_q.size() - n_req, t0 + 1);
        end
        checks++;
        if (req_a_q[n_req] !== 32'h3f800000) begin
            errors++;
            $display("FAIL basic_opA got=%h exp=3f800000", req_a_q[n_req]);
        end
        checks++;
        if (busy_cnt - n_busy != 2) begin
            errors++;
            $display("FAIL basic_busy got=%0d exp=2", busy_cnt - n_busy);
        end
        checks++;
        if (rsp_cyc_q[0] != t0 + 7 || rsp_vec_q[0] !== 4'b0001) begin
            errors++;
            $display("FAIL basic_rsp_time got=%0d/%b exp=%0d/0001",
                     rsp_cyc_q[0], rsp_vec_q[0], t0 + 7);
        end
        checks++;
        if (rsp_data_q[0] !== 32'h3f800000 || rsp_flag_q[0] !== 3'b000) begin
            errors++;
            $display("FAIL basic_data got=%h/%b exp=3f800000/000",
                     rsp_data_q[0], rsp_flag_q[0]);
        end
        idle(10);
    endtask

    task automatic test_round_robin();
        int n_acc, n_rsp;
        bit ok;
        int exp_order[5];
        exp_order = '{1, 2, 3, 0, 1};
        rst = 1'b0;
        idle(1);
        rst = 1'b1;
        idle(1);
        fma_lat = 1;
        fma_ans = 32'h40000000;
        n_acc = acc_idx_q.size();
        n_rsp = rsp_cyc_q.size();
        for (int i = 0; i < NREQ; i++) begin
            req_a_in[i] = 32'h3f800000;
            req_b_in[i] = 32'h40000000;
        end
        req_valid_in = 4'b1110;
        wait_rsp(n_rsp + 3, 200, ok);
        req_valid_in = 4'b0011;
        wait_rsp(n_rsp + 5, 200, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL rr_rsp got=%0d exp=5", rsp_cyc_q.size() - n_rsp);
            return;
        end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (acc_idx_q[n_acc + i] != exp_order[i]) begin
                errors++;
                $display("FAIL rr_grant%0d got=%0d exp=%0d",
                         i, acc_idx_q[n_acc + i], exp_order[i]);
            end
        end
        idle(10);
    endtask

    task automatic test_zero();
        int t0, n_req, n_rsp;
        bit ok;
        n_req = req_cyc_q.size();
        n_rsp = rsp_cyc_q.size();
        req_a_in[2] = 32'h00000000;
        req_b_in[2] = 32'hc1a00000;
        req_valid_in[2] = 1'b1;
        t0 = cyc;
        wait_rsp(n_rsp + 1, 20, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL zero_rsp got=none exp=response");
            return;
        end
        checks++;
        if (rsp_cyc_q[n_rsp] != t0 + 1 || rsp_vec_q[n_rsp] !== 4'b0100) begin
            errors++;
            $display("FAIL zero_time got=%0d/%b exp=%0d/0100",
                     rsp_cyc_q[n_rsp], rsp_vec_q[n_rsp], t0 + 1);
        end
        checks++;
        if (rsp_data_q[n_rsp] !== 32'h80000000) begin
            errors++;
            $display("FAIL zero_data got=%h exp=80000000", rsp_data_q[n_rsp]);
        end
        idle(4);
        checks++;
        if (req_cyc_q.size() != n_req) begin
            errors++;
            $display("FAIL zero_nofma got=%0d exp=0",
                     req_cyc_q.size() - n_req);
        end
    endtask

    task automatic test_timeout();
        int n_req, n_rsp, n_busy, q;
        bit ok;
        fma_lat = 0;
        n_req = req_cyc_q.size();
        n_rsp = rsp_cyc_q.size();
        n_busy = busy_cnt;
        req_a_in[0] = 32'h40000000;
        req_b_in[0] = 32'h40400000;
        req_valid_in[0] = 1'b1;
        wait_rsp(n_rsp + 1, 40, ok);
        checks++;
        if (!ok || req_cyc_q.size() <= n_req) begin
            errors++;
            $display("FAIL tmo_rsp got=none exp=response");
            return;
        end
        q = req_cyc_q[n_req];
        checks++;
        if (rsp_cyc_q[n_rsp] != q + 13) begin
            errors++;
            $display("FAIL tmo_time got=%0d exp=%0d", rsp_cyc_q[n_rsp], q + 13);
        end
        checks++;
        if (rsp_flag_q[n_rsp] !== 3'b001 || rsp_data_q[n_rsp] !== 32'h0) begin
            errors++;
            $display("FAIL tmo_flags got=%b/%h exp=001/0",
                     rsp_flag_q[n_rsp], rsp_data_q[n_rsp]);
        end
        checks++;
        if (busy_cnt != n_busy) begin
            errors++;
            $display("FAIL tmo_busy got=%0d exp=0", busy_cnt - n_busy);
        end
        idle(10);
        fma_lat = 2;
        fma_ans = 32'h40c00000;
        req_a_in[3] = 32'h40000000;
        req_b_in[3] = 32'h40400000;
        req_valid_in[3] = 1'b1;
        wait_rsp(n_rsp + 2, 40, ok);
        checks++;
        if (!ok || rsp_data_q[n_rsp + 1] !== 32'h40c00000
                || rsp_flag_q[n_rsp + 1] !== 3'b000) begin
            errors++;
            $display("FAIL tmo_recover got=%0d exp=40c00000/000", ok);
        end
        idle(10);
    endtask

    task automatic test_back_to_back();
        int n_req, n_rsp, n_acc;
        bit ok;
        fma_lat = 2;
        fma_ans = 32'h41000000;
        n_req = req_cyc_q.size();
        n_rsp = rsp_cyc_q.size();
        n_acc = acc_cyc_q.size();
        req_a_in[0] = 32'h40000000;
        req_b_in[0] = 32'h40800000;
        req_a_in[1] = 32'h40800000;
        req_b_in[1] = 32'h40000000;
        req_valid_in = 4'b0011;
        wait_rsp(n_rsp + 2, 60, ok);
        checks++;
        if (!ok || req_cyc_q.size() - n_req != 2) begin
            errors++;
            $display("FAIL b2b_rsp got=%0d exp=2 responses", ok);
            return;
        end
        checks++;
        if (req_cyc_q[n_req + 1] - req_cyc_q[n_req] != 8) begin
            errors++;
            $display("FAIL b2b_gap got=%0d exp=8",
                     req_cyc_q[n_req + 1] - req_cyc_q[n_req]);
        end
        checks++;
        if (acc_cyc_q[n_acc + 1] != rsp_cyc_q[n_rsp] + 1) begin
            errors++;
            $display("FAIL b2b_accept got=%0d exp=%0d",
                     acc_cyc_q[n_acc + 1], rsp_cyc_q[n_rsp] + 1);
        end
        checks++;
        if (rsp_vec_q[n_rsp] !== 4'b0001 || rsp_vec_q[n_rsp + 1] !== 4'b0010) begin
            errors++;
            $display("FAIL b2b_order got=%b,%b exp=0001,0010",
                     rsp_vec_q[n_rsp], rsp_vec_q[n_rsp + 1]);
        end
        idle(10);
    endtask

    task automatic test_reset_mid();
        int n_req, n_rsp;
        bit ok;
        fma_lat = 0;
        n_req = req_cyc_q.size();
        n_rsp = rsp_cyc_q.size();
        req_a_in[1] = 32'h40400000;
        req_b_in[1] = 32'h40400000;
        req_valid_in[1] = 1'b1;
        idle(4);
        checks++;
        if (req_cyc_q.size() - n_req != 1 || fma_float_0_out !== 32'h40400000) begin
            errors++;
            $display("FAIL rmid_wait got=%0d/%h exp=1/40400000",
                     req_cyc_q.size() - n_req, fma_float_0_out);
        end
        req_valid_in[1] = 1'b1;
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if ({fma_req_out, fma_busy_out} !== 2'b00 || fma_float_0_out !== 32'h0
                || fma_float_1_out !== 32'h0 || req_ready_out !== 4'b0000
                || rsp_valid_out !== 4'b0000) begin
            errors++;
            $display("FAIL rmid_async got=%b%b/%h/%b exp=00/0/0000",
                     fma_req_out, fma_busy_out, fma_float_0_out, req_ready_out);
        end
        idle(2);
        ready_at = -1;
        fma_lat = 2;
        fma_ans = 32'h41100000;
        rst = 1'b1;
        wait_rsp(n_rsp + 1, 40, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL rmid_rsp got=none exp=response");
            return;
        end
        checks++;
        if (rsp_vec_q[n_rsp] !== 4'b0010 || rsp_data_q[n_rsp] !== 32'h41100000
                || rsp_flag_q[n_rsp] !== 3'b000) begin
            errors++;
            $display("FAIL rmid_data got=%b/%h/%b exp=0010/41100000/000",
                     rsp_vec_q[n_rsp], rsp_data_q[n_rsp], rsp_flag_q[n_rsp]);
        end
        idle(4);
        checks++;
        if (rsp_cyc_q.size() - n_rsp != 1) begin
            errors++;
            $display("FAIL rmid_count got=%0d exp=1", rsp_cyc_q.size() - n_rsp);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_round_robin();
        test_zero();
        test_timeout();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
